// File: rtl/branch_resolve_unit.sv
// Resolves B-type/JAL/JALR, checks the front-end prediction and flags redirects; one registered slot.
// Latency 1 cycle; ready_o = ~valid_o | ready_i, the slot holds while stalled and flush_i kills it.
module branch_resolve_unit #(
  parameter int XLEN       = 64,
  parameter int CNT_W      = 32,
  parameter int ILEN_BYTES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [XLEN-1:0]  pc_i,
  input  logic [XLEN-1:0]  opr_a_i,
  input  logic [XLEN-1:0]  opr_b_i,
  input  logic [XLEN-1:0]  imm_i,
  input  logic             is_b_type_i,
  input  logic             is_jal_i,
  input  logic             is_jalr_i,
  input  logic [2:0]       funct3_i,
  input  logic             pred_taken_i,
  input  logic [XLEN-1:0]  pred_target_i,
  input  logic             flush_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic             taken_o,
  output logic [XLEN-1:0]  target_o,
  output logic [XLEN-1:0]  link_o,
  output logic             redirect_o,
  output logic [XLEN-1:0]  redirect_pc_o,
  output logic             misaligned_o,
  output logic [CNT_W-1:0] ctrl_cnt_o,
  output logic [CNT_W-1:0] mispred_cnt_o
);

  typedef struct packed {
    logic            taken;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] link;
    logic            redirect;
    logic [XLEN-1:0] redirect_pc;
    logic            misaligned;
  } res_t;

  res_t            res_q;
  res_t            res_d;
  logic            vld_q;
  logic            accept;
  logic            is_ctrl;
  logic            cond;
  logic            taken;
  logic            mispred;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] fall_thru;

  assign ready_o = ~vld_q | ready_i;
  assign accept  = valid_i & ready_o & ~flush_i;
  assign is_ctrl = is_b_type_i | is_jal_i | is_jalr_i;

  always_comb begin
    cond = 1'b0;
    unique case (funct3_i)
      3'b000:  cond = (opr_a_i == opr_b_i);
      3'b001:  cond = (opr_a_i != opr_b_i);
      3'b100:  cond = ($signed(opr_a_i) <  $signed(opr_b_i));
      3'b101:  cond = ($signed(opr_a_i) >= $signed(opr_b_i));
      3'b110:  cond = (opr_a_i <  opr_b_i);
      3'b111:  cond = (opr_a_i >= opr_b_i);
      default: cond = 1'b0;
    endcase
  end

  always_comb begin
    fall_thru = pc_i + XLEN'(ILEN_BYTES);
    // JALR wins over JAL, which wins over a conditional branch
    if (is_jalr_i) begin
      taken  = 1'b1;
      target = (opr_a_i + imm_i) & ~XLEN'(1);
    end else if (is_jal_i) begin
      taken  = 1'b1;
      target = pc_i + imm_i;
    end else begin
      taken  = is_b_type_i & cond;
      target = pc_i + imm_i;
    end
    mispred = (taken != pred_taken_i) |
              (taken & pred_taken_i & (target != pred_target_i));

    res_d.taken       = taken;
    res_d.target      = target;
    res_d.link        = fall_thru;
    res_d.misaligned  = taken & target[1];
    res_d.redirect    = mispred & ~res_d.misaligned;
    res_d.redirect_pc = taken ? target : fall_thru;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q         <= 1'b0;
      res_q         <= '0;
      ctrl_cnt_o    <= '0;
      mispred_cnt_o <= '0;
    end else begin
      if (flush_i) begin
        vld_q <= 1'b0;
        res_q <= '0;
      end else if (accept) begin
        vld_q <= 1'b1;
        res_q <= res_d;
      end else if (vld_q & ready_i) begin
        vld_q <= 1'b0;
        res_q <= '0;
      end
      if (accept & is_ctrl & (ctrl_cnt_o != '1))
        ctrl_cnt_o <= ctrl_cnt_o + CNT_W'(1);
      if (accept & res_d.redirect & (mispred_cnt_o != '1))
        mispred_cnt_o <= mispred_cnt_o + CNT_W'(1);
    end
  end

  assign valid_o       = vld_q;
  assign taken_o       = res_q.taken;
  assign target_o      = res_q.target;
  assign link_o        = res_q.link;
  assign redirect_o    = res_q.redirect;
  assign redirect_pc_o = res_q.redirect_pc;
  assign misaligned_o  = res_q.misaligned;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit (XLEN=64, CNT_W=4 so saturation is reachable).
module tb_branch_resolve_unit;
  localparam int XLEN  = 64;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             valid_i, ready_o;
  logic [XLEN-1:0]  pc_i, opr_a_i, opr_b_i, imm_i, pred_target_i;
  logic             is_b_type_i, is_jal_i, is_jalr_i;
  logic [2:0]       funct3_i;
  logic             pred_taken_i, flush_i;
  logic             valid_o, ready_i, taken_o, redirect_o, misaligned_o;
  logic [XLEN-1:0]  target_o, link_o, redirect_pc_o;
  logic [CNT_W-1:0] ctrl_cnt_o, mispred_cnt_o;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  branch_resolve_unit #(.XLEN(XLEN), .CNT_W(CNT_W), .ILEN_BYTES(4)) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .ready_o(ready_o),
    .pc_i(pc_i), .opr_a_i(opr_a_i), .opr_b_i(opr_b_i), .imm_i(imm_i),
    .is_b_type_i(is_b_type_i), .is_jal_i(is_jal_i), .is_jalr_i(is_jalr_i),
    .funct3_i(funct3_i), .pred_taken_i(pred_taken_i), .pred_target_i(pred_target_i),
    .flush_i(flush_i), .valid_o(valid_o), .ready_i(ready_i), .taken_o(taken_o),
    .target_o(target_o), .link_o(link_o), .redirect_o(redirect_o),
    .redirect_pc_o(redirect_pc_o), .misaligned_o(misaligned_o),
    .ctrl_cnt_o(ctrl_cnt_o), .mispred_cnt_o(mispred_cnt_o)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // kind: 0 none, 1 b-type, 2 jal, 3 jalr, 4 jalr+b-type
  task automatic set_in(input int kind, input logic [2:0] f3, input logic [63:0] pc,
                        input logic [63:0] a, input logic [63:0] b, input logic [63:0] imm,
                        input logic pt, input logic [63:0] ptgt);
    valid_i       = 1'b1;
    is_b_type_i   = (kind == 1) || (kind == 4);
    is_jal_i      = (kind == 2);
    is_jalr_i     = (kind == 3) || (kind == 4);
    funct3_i      = f3;
    pc_i          = pc;
    opr_a_i       = a;
    opr_b_i       = b;
    imm_i         = imm;
    pred_taken_i  = pt;
    pred_target_i = ptgt;
  endtask

  task automatic send(input int kind, input logic [2:0] f3, input logic [63:0] pc,
                      input logic [63:0] a, input logic [63:0] b, input logic [63:0] imm,
                      input logic pt, input logic [63:0] ptgt);
    set_in(kind, f3, pc, a, b, imm, pt, ptgt);
    step();
    valid_i = 1'b0;
  endtask

  task automatic chk_res(input string tag, input logic tk, input logic [63:0] tgt,
                         input logic rd, input logic [63:0] rpc, input logic mis,
                         input logic [3:0] cc, input logic [3:0] mc);
    chk({tag, ".valid"},    valid_o, 1'b1);
    chk({tag, ".taken"},    taken_o, tk);
    chk({tag, ".target"},   target_o, tgt);
    chk({tag, ".redirect"}, redirect_o, rd);
    chk({tag, ".rpc"},      redirect_pc_o, rpc);
    chk({tag, ".misalign"}, misaligned_o, mis);
    chk({tag, ".ctrl_cnt"}, ctrl_cnt_o, cc);
    chk({tag, ".misp_cnt"}, mispred_cnt_o, mc);
  endtask

  initial begin
    rst = 1'b1; valid_i = 1'b0; flush_i = 1'b0; ready_i = 1'b1;
    set_in(0, 3'b000, 64'h0, 64'h0, 64'h0, 64'h0, 1'b0, 64'h0);
    valid_i = 1'b0;
    step(); step();
    chk("rst.valid", valid_o, 1'b0);
    chk("rst.redirect", redirect_o, 1'b0);
    chk("rst.target", target_o, 64'h0);
    chk("rst.link", link_o, 64'h0);
    chk("rst.ctrl_cnt", ctrl_cnt_o, 4'h0);
    chk("rst.misp_cnt", mispred_cnt_o, 4'h0);
    rst = 1'b0;
    step();
    chk("rst.ready", ready_o, 1'b1);

    // BLT -1 < 1, predicted not taken
    send(1, 3'b100, 64'h1000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 64'h40, 1'b0, 64'h0);
    chk_res("blt", 1'b1, 64'h1040, 1'b1, 64'h1040, 1'b0, 4'd1, 4'd1);
    chk("blt.link", link_o, 64'h1004);

    // BGEU all-ones >= 1, correctly predicted
    send(1, 3'b111, 64'h3000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 64'h100, 1'b1, 64'h3100);
    chk_res("bgeu", 1'b1, 64'h3100, 1'b0, 64'h3100, 1'b0, 4'd2, 4'd1);

    // BGE signed -1 >= 1 false, predicted taken
    send(1, 3'b101, 64'h3000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 64'h100, 1'b1, 64'h3100);
    chk_res("bge", 1'b0, 64'h3100, 1'b1, 64'h3004, 1'b0, 4'd3, 4'd2);

    // JALR to 0x2002: misaligned, no redirect, not counted as mispredict
    send(3, 3'b000, 64'h4000, 64'h2003, 64'h0, 64'h0, 1'b0, 64'h0);
    chk_res("jalr_mis", 1'b1, 64'h2002, 1'b0, 64'h2002, 1'b1, 4'd4, 4'd2);
    chk("jalr_mis.link", link_o, 64'h4004);

    send(3, 3'b000, 64'h4000, 64'h2001, 64'h0, 64'h0, 1'b0, 64'h0);
    chk_res("jalr_ok", 1'b1, 64'h2000, 1'b1, 64'h2000, 1'b0, 4'd5, 4'd3);

    // Backpressure: slot holds, no accept, no counting
    ready_i = 1'b0;
    set_in(1, 3'b000, 64'h5000, 64'h5, 64'h5, 64'h8, 1'b1, 64'h5008);
    #1;
    chk("bp.ready_o", ready_o, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp.ready_o", ready_o, 1'b0);
      chk_res("bp.hold", 1'b1, 64'h2000, 1'b1, 64'h2000, 1'b0, 4'd5, 4'd3);
    end
    ready_i = 1'b1;
    #1;
    chk("bp.release_ready", ready_o, 1'b1);
    step();
    valid_i = 1'b0;
    chk_res("beq", 1'b1, 64'h5008, 1'b0, 64'h5008, 1'b0, 4'd6, 4'd3);

    // Flush while holding a result with a new mispredicting branch incoming
    set_in(1, 3'b001, 64'h5100, 64'h1, 64'h2, 64'h20, 1'b0, 64'h0);
    flush_i = 1'b1;
    step();
    flush_i = 1'b0; valid_i = 1'b0;
    chk("flush.valid", valid_o, 1'b0);
    chk("flush.redirect", redirect_o, 1'b0);
    chk("flush.ctrl_cnt", ctrl_cnt_o, 4'd6);
    chk("flush.misp_cnt", mispred_cnt_o, 4'd3);

    // Non-control instruction predicted taken is a mispredict
    send(0, 3'b000, 64'h6000, 64'h0, 64'h0, 64'h10, 1'b1, 64'h6010);
    chk_res("nonctl_pt", 1'b0, 64'h6010, 1'b1, 64'h6004, 1'b0, 4'd6, 4'd4);

    // Reserved funct3 010 never taken
    send(1, 3'b010, 64'h6100, 64'h1, 64'h2, 64'h10, 1'b0, 64'h0);
    chk_res("f3_010", 1'b0, 64'h6110, 1'b0, 64'h6104, 1'b0, 4'd7, 4'd4);

    // JALR beats b-type (BEQ would be not-taken)
    send(4, 3'b000, 64'h7000, 64'h8000, 64'h1, 64'h4, 1'b1, 64'h8004);
    chk_res("prio", 1'b1, 64'h8004, 1'b0, 64'h8004, 1'b0, 4'd8, 4'd4);

    // Drain clears the slot
    step();
    chk("drain.valid", valid_o, 1'b0);
    chk("drain.redirect", redirect_o, 1'b0);

    // Reset mid-stream
    send(2, 3'b000, 64'h9000, 64'h0, 64'h0, 64'h80, 1'b0, 64'h0);
    chk_res("jal", 1'b1, 64'h9080, 1'b1, 64'h9080, 1'b0, 4'd9, 4'd5);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mrst.valid", valid_o, 1'b0);
    chk("mrst.taken", taken_o, 1'b0);
    chk("mrst.target", target_o, 64'h0);
    chk("mrst.rpc", redirect_pc_o, 64'h0);
    chk("mrst.ctrl_cnt", ctrl_cnt_o, 4'd0);
    chk("mrst.misp_cnt", mispred_cnt_o, 4'd0);

    // 20 back-to-back mispredicting BEQs saturate both counters
    set_in(1, 3'b000, 64'h100, 64'h7, 64'h7, 64'h10, 1'b0, 64'h0);
    for (int i = 0; i < 20; i++) step();
    valid_i = 1'b0;
    chk("sat.ctrl_cnt", ctrl_cnt_o, 4'hF);
    chk("sat.misp_cnt", mispred_cnt_o, 4'hF);

    // Fall-through wraps at the top of the address space
    step();
    send(0, 3'b000, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0, 64'h0, 64'h0, 1'b0, 64'h0);
    chk("wrap.valid", valid_o, 1'b1);
    chk("wrap.link", link_o, 64'h0);
    chk("wrap.rpc", redirect_pc_o, 64'h0);
    chk("wrap.redirect", redirect_o, 1'b0);
    chk("wrap.ctrl_cnt", ctrl_cnt_o, 4'hF);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
Parametrised, pipelined branch/jump resolution stage for the execute unit. It evaluates B-type, JAL and JALR instructions and computes the actual target and the link address. It checks the front-end prediction and raises a registered redirect on mispredict. One registered output slot with valid/ready handshake, flush support, and saturating performance counters.

Parameters:
XLEN, 64, operand/PC width (32 or 64)
CNT_W, 32, width of each performance counter
ILEN_BYTES, 4, sequential-PC increment for link/fall-through

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
valid_i  in  1  upstream instruction valid
ready_o  out  1  unit can accept this cycle
pc_i  in  XLEN  instruction PC
opr_a_i  in  XLEN  rs1 value
opr_b_i  in  XLEN  rs2 value
imm_i  in  XLEN  sign-extended immediate
is_b_type_i  in  1  conditional branch
is_jal_i  in  1  JAL
is_jalr_i  in  1  JALR
funct3_i  in  3  branch condition (BEQ 000, BNE 001, BLT 100, BGE 101, BLTU 110, BGEU 111)
pred_taken_i  in  1  front-end predicted taken
pred_target_i  in  XLEN  front-end predicted target
flush_i  in  1  kill held result and incoming instruction
valid_o  out  1  result valid
ready_i  in  1  downstream accepts result
taken_o  out  1  actual taken
target_o  out  XLEN  actual taken target
link_o  out  XLEN  pc_i + ILEN_BYTES
redirect_o  out  1  mispredict; fetch must restart at redirect_pc_o
redirect_pc_o  out  XLEN  correct next PC
misaligned_o  out  1  taken target not 4-byte aligned
ctrl_cnt_o  out  CNT_W  resolved control instructions
mispred_cnt_o  out  CNT_W  mispredicts

Behaviour:
- Reset (rst=1 at posedge): valid_o=0, and all data outputs, redirect_o, misaligned_o and both counters =0; ready_o=1 in the following cycle.
- Handshake: accept = valid_i & ready_o & ~flush_i. ready_o = ~valid_o | ready_i (combinational; pass-through when the slot drains). Latency 1 cycle from accept to valid_o.
- Output register holds stable while valid_o & ~ready_i. It clears when valid_o & ready_i & ~accept.
- flush_i: next cycle valid_o=0 and redirect_o=0. No accept that cycle. Counters are not updated for the flushed input. flush_i has priority over ready_i.
- Condition evaluation: signed/unsigned compares at full XLEN. funct3 010/011 with is_b_type_i gives not-taken.
- Taken: is_b_type_i & cond, or is_jal_i, or is_jalr_i. With no control flag set, taken=0.
- Target: B/JAL = pc_i + imm_i. JALR = (opr_a_i + imm_i) with bit0 cleared. All sums are modulo 2^XLEN.
- Fall-through = pc_i + ILEN_BYTES (wraps). link_o always equals fall-through.
- redirect_pc_o = taken ? target : fall-through.
- Mispredict = (taken != pred_taken_i) | (taken & pred_taken_i & target != pred_target_i). This includes a non-control instruction predicted taken.
- misaligned_o = taken & target[1]. When misaligned_o=1, redirect_o is forced 0; the trap path handles the instruction.
- redirect_o is meaningful only while valid_o=1 and is 0 otherwise.
- Multiple control flags set: precedence is jalr > jal > b-type.
- Counters: on accept of a control instruction, ctrl_cnt +1. On accept with mispredict (and not misaligned), mispred_cnt +1. Both saturate at all-ones and never wrap.

Test Plan:
- XLEN=64. BLT with a=-1, b=1, pc=0x1000, imm=0x40, pred_taken=0 -> next cycle: taken=1, target=0x1040, redirect=1, redirect_pc=0x1040, mispred_cnt=1.
- BGEU with a=0xFFFF_FFFF_FFFF_FFFF, b=1, pred_taken=1, pred_target=pc+imm -> taken=1, redirect=0. Repeat as BGE -> taken=0, redirect=1, redirect_pc=pc+4.
- JALR with a=0x2003, imm=0 -> target=0x2002, misaligned=1, redirect=0, link=pc+4. Repeat with a=0x2001 -> target=0x2000, misaligned=0.
- Backpressure: hold ready_i=0 for 3 cycles with valid_i=1 -> outputs stable, ready_o=0, no counter change. Then raise ready_i -> next instruction is accepted in the same cycle.
- flush_i asserted while valid_o=1 and valid_i=1 -> next cycle valid_o=0 and counters unchanged. Also rst mid-stream -> all outputs 0.
- CNT_W=4: drive 20 mispredicting branches -> both counters saturate at 0xF. pc=0xFFFF_FFFF_FFFF_FFFC with non-branch -> link_o=0 (wrap).
